// File: rtl/marv32_pkg.sv
// Shared definitions for the MARV32 store path.
// Holds the store-size (funct3) encodings, the AHB HTRANS encodings,
// the bus FSM state type and the store-queue entry payload.
package marv32_pkg;

    localparam int unsigned ENTRY_AW = 32;

    localparam logic [1:0] F3_SB  = 2'b00;
    localparam logic [1:0] F3_SH  = 2'b01;
    localparam logic [1:0] F3_SW  = 2'b10;
    localparam logic [1:0] F3_ILL = 2'b11;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } bus_state_e;

    // One queued store: word-aligned address, lane-steered data, byte strobes.
    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [31:0]         data;
        logic [3:0]          mask;
    } store_entry_t;

endpackage

// File: rtl/marv32_store_align.sv
// Store lane steering and alignment check (purely combinational).
// Ports:
//   funct3       store size (SB/SH/SW/illegal)
//   addr_lo      low two bits of the store byte address
//   rs2          store source data
//   data_c       data replicated onto the byte lanes
//   mask_c       byte strobes for the addressed lanes
//   misaligned_c request is misaligned or has an illegal size
module marv32_store_align
    import marv32_pkg::*;
(
    input  logic [1:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    output logic [31:0] data_c,
    output logic [3:0]  mask_c,
    output logic        misaligned_c
);

    always_comb begin
        data_c       = rs2;
        mask_c       = 4'b1111;
        misaligned_c = 1'b0;
        case (funct3)
            F3_SB: begin
                data_c = {4{rs2[7:0]}};
                mask_c = 4'b0001 << addr_lo;
            end
            F3_SH: begin
                data_c       = {2{rs2[15:0]}};
                mask_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned_c = addr_lo[0];
            end
            F3_SW: begin
                misaligned_c = (addr_lo != 2'b00);
            end
            default: begin
                mask_c       = 4'b0000;
                misaligned_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/marv32_store_queue.sv
// Store queue with an AHB-lite write master.
// Accepts aligned stores into a DEPTH-entry FIFO and drains them one at a
// time as an address phase (NONSEQ) followed by a data phase.
// Ports:
//   clk_in, reset_n_in        clock, async active-low reset
//   funct3_in, iadder_in,     store request (size, byte address, data,
//   rs2_in, mem_wr_req_in     request strobe)
//   ahb_ready_in              HREADY
//   d_addr_out, data_out,     HADDR, HWDATA, byte strobes,
//   wr_mask_out,              HTRANS, HWRITE
//   ahb_htrans_out, wr_req_out
//   stall_out                 queue full, request rejected
//   misaligned_out            pulse one cycle after a rejected misaligned request
//   empty_out                 queue empty and bus idle
module marv32_store_queue
    import marv32_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk_in,
    input  logic          reset_n_in,
    input  logic [1:0]    funct3_in,
    input  logic [AW-1:0] iadder_in,
    input  logic [31:0]   rs2_in,
    input  logic          mem_wr_req_in,
    input  logic          ahb_ready_in,
    output logic [AW-1:0] d_addr_out,
    output logic [31:0]   data_out,
    output logic [3:0]    wr_mask_out,
    output logic [1:0]    ahb_htrans_out,
    output logic          wr_req_out,
    output logic          stall_out,
    output logic          misaligned_out,
    output logic          empty_out
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    bus_state_e   state, next_state;
    logic [CW-1:0] wr_ptr, rd_ptr, count, count_next;
    store_entry_t mem [DEPTH];
    store_entry_t head;

    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        st_mis;
    logic        q_empty, q_full, push, pop;

    marv32_store_align u_align (
        .funct3       (funct3_in),
        .addr_lo      (iadder_in[1:0]),
        .rs2          (rs2_in),
        .data_c       (st_data),
        .mask_c       (st_mask),
        .misaligned_c (st_mis)
    );

    // Wrap-bit pointer compare; stall uses the registered count.
    assign q_empty    = (wr_ptr == rd_ptr);
    assign q_full     = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign stall_out  = (count == CW'(DEPTH));
    assign push       = mem_wr_req_in && !stall_out && !q_full && !st_mis;
    assign pop        = (state == ST_DATA) && ahb_ready_in;
    assign count_next = count + CW'(push) - CW'(pop);
    assign head       = mem[rd_ptr[IW-1:0]];
    assign empty_out  = (count == '0) && (state == ST_IDLE);

    // Entry storage; never written at the head while it is non-empty.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr[IW-1:0]] <= '{addr: ENTRY_AW'({iadder_in[AW-1:2], 2'b00}),
                                     data: st_data,
                                     mask: st_mask};
        end
    end

    // Pointers, occupancy and the misaligned pulse.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            misaligned_out <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (pop)  rd_ptr <= rd_ptr + CW'(1);
            count          <= count_next;
            misaligned_out <= mem_wr_req_in && st_mis;
        end
    end

    // Bus FSM state register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= ST_IDLE;
        else             state <= next_state;
    end

    // Bus FSM next state and phase outputs.
    always_comb begin
        next_state     = state;
        ahb_htrans_out = HTRANS_IDLE;
        wr_req_out     = 1'b0;
        d_addr_out     = '0;
        data_out       = '0;
        wr_mask_out    = '0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) next_state = ST_ADDR;
            end
            ST_ADDR: begin
                ahb_htrans_out = HTRANS_NONSEQ;
                wr_req_out     = 1'b1;
                d_addr_out     = AW'(head.addr);
                wr_mask_out    = head.mask;
                if (ahb_ready_in) next_state = ST_DATA;
            end
            ST_DATA: begin
                data_out    = head.data;
                wr_mask_out = head.mask;
                // Occupancy after this pop (and any same-cycle push) picks the next phase.
                if (ahb_ready_in) next_state = (count_next != '0) ? ST_ADDR : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_marv32_store_queue.sv
// Scoreboard bench for marv32_store_queue (DEPTH=4, AW=32).
module tb_marv32_store_queue;
    import marv32_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  funct3;
    logic [31:0] iadder;
    logic [31:0] rs2;
    logic        req;
    logic        ready;
    logic [31:0] d_addr;
    logic [31:0] data;
    logic [3:0]  wr_mask;
    logic [1:0]  htrans;
    logic        wr_req;
    logic        stall;
    logic        misaligned;
    logic        empty;

    int errors = 0;
    int checks = 0;

    store_entry_t exp_q[$];
    store_entry_t cur;
    logic         in_data     = 1'b0;
    logic         mis_issue   = 1'b0;
    logic         mis_exp_cur = 1'b0;

    marv32_store_queue #(.DEPTH(4), .AW(32)) dut (
        .clk_in         (clk),
        .reset_n_in     (reset_n),
        .funct3_in      (funct3),
        .iadder_in      (iadder),
        .rs2_in         (rs2),
        .mem_wr_req_in  (req),
        .ahb_ready_in   (ready),
        .d_addr_out     (d_addr),
        .data_out       (data),
        .wr_mask_out    (wr_mask),
        .ahb_htrans_out (htrans),
        .wr_req_out     (wr_req),
        .stall_out      (stall),
        .misaligned_out (misaligned),
        .empty_out      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one store in the next cycle; push the expected transfer if it should be accepted.
    task automatic store(input logic [1:0] a_f3, input logic [31:0] a_addr, input logic [31:0] a_rs2,
                         input logic a_rdy, input logic exp_stall, input logic exp_mis,
                         input logic [31:0] exp_data, input logic [3:0] exp_mask);
        store_entry_t e;
        @(negedge clk);
        chk("stall", 32'(stall), 32'(exp_stall));
        funct3    = a_f3;
        iadder    = a_addr;
        rs2       = a_rs2;
        req       = 1'b1;
        ready     = a_rdy;
        mis_issue = exp_mis;
        if (!exp_stall && !exp_mis) begin
            e.addr = a_addr & 32'hFFFF_FFFC;
            e.data = exp_data;
            e.mask = exp_mask;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic a_rdy);
        repeat (n) begin
            @(negedge clk);
            req       = 1'b0;
            ready     = a_rdy;
            mis_issue = 1'b0;
        end
    endtask

    // Drain with ready high, bounded; then expect an empty, idle queue.
    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (n < budget) begin
            idle(1, 1'b1);
            #2;
            if (empty && exp_q.size() == 0 && !in_data) break;
            n++;
        end
        chk({name, "_empty"}, 32'(empty), 32'd1);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every bus phase and misaligned pulse against the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (reset_n) begin
            if (misaligned || mis_exp_cur)
                chk("misaligned", 32'(misaligned), 32'(mis_exp_cur));
            mis_exp_cur = mis_issue;
            if (in_data) begin
                chk("data_phase_data", data, cur.data);
                chk("data_phase_mask", 32'(wr_mask), 32'(cur.mask));
                chk("data_phase_addr0", d_addr, 32'd0);
                chk("data_phase_htrans", 32'(htrans), 32'(HTRANS_IDLE));
                if (ready) in_data = 1'b0;
            end else if (htrans == HTRANS_NONSEQ) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_nonseq: got addr %h expected no transfer", d_addr);
                end else begin
                    cur = exp_q[0];
                    chk("addr_phase_addr", d_addr, cur.addr);
                    chk("addr_phase_mask", 32'(wr_mask), 32'(cur.mask));
                    chk("addr_phase_hwrite", 32'(wr_req), 32'd1);
                    chk("addr_phase_data0", data, 32'd0);
                    if (ready) begin
                        void'(exp_q.pop_front());
                        in_data = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        funct3  = 2'b00;
        iadder  = '0;
        rs2     = '0;
        req     = 1'b0;
        ready   = 1'b1;
        #1;
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_hwrite", 32'(wr_req), 32'd0);
        chk("rst_addr", d_addr, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mis", 32'(misaligned), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // SB at 0x1003 with 2-cycle latency to NONSEQ.
        store(F3_SB, 32'h0000_1003, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 4'b1000);
        idle(1, 1'b1);
        #2 chk("latency_idle", 32'(htrans), 32'(HTRANS_IDLE));
        idle(1, 1'b1);
        #2 chk("latency_nonseq", 32'(htrans), 32'(HTRANS_NONSEQ));
        wait_empty("sb", 20);

        // Halfword/byte steering and misaligned/illegal rejects.
        store(F3_SH,  32'h0000_2002, 32'h1234_BEEF, 1'b1, 1'b0, 1'b0, 32'hBEEF_BEEF, 4'b1100);
        store(F3_SW,  32'h0000_2001, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 32'h0, 4'b0000);
        store(F3_ILL, 32'h0000_2000, 32'h6666_6666, 1'b1, 1'b0, 1'b1, 32'h0, 4'b0000);
        store(F3_SH,  32'h0000_2001, 32'h7777_7777, 1'b1, 1'b0, 1'b1, 32'h0, 4'b0000);
        store(F3_SB,  32'h0000_2001, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 32'h7777_7777, 4'b0010);
        store(F3_SH,  32'h0000_2000, 32'h0000_CAFE, 1'b1, 1'b0, 1'b0, 32'hCAFE_CAFE, 4'b0011);
        wait_empty("steer", 30);

        // Fill with ready low: fifth request sees stall.
        for (int i = 0; i < 5; i++)
            store(F3_SW, 32'h0000_3000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0,
                  (i == 4), 1'b0, 32'h1111_0000 + 32'(i), 4'b1111);
        idle(1, 1'b0);
        #2 chk("full_stall_held", 32'(stall), 32'd1);
        wait_empty("full", 40);

        // Wait states in the address phase then in the data phase.
        store(F3_SW, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1111);
        idle(1, 1'b0);
        idle(3, 1'b0);
        #2 chk("addr_hold_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
        idle(1, 1'b1);
        idle(3, 1'b0);
        #2 chk("data_hold_data", data, 32'hDEAD_BEEF);
        idle(1, 1'b1);
        wait_empty("hold", 20);

        // Ten stores through the queue, wrapping the pointers.
        for (int i = 0; i < 10; i++) begin
            store(F3_SW, 32'h0000_5000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1,
                  1'b0, 1'b0, 32'hA000_0000 + 32'(i), 4'b1111);
            idle(1, 1'b1);
        end
        wait_empty("wrap", 40);

        // Reset during a data phase with three entries queued.
        for (int i = 0; i < 3; i++)
            store(F3_SW, 32'h0000_6000 + 32'(4 * i), 32'h6666_0000 + 32'(i), 1'b0,
                  1'b0, 1'b0, 32'h6666_0000 + 32'(i), 4'b1111);
        idle(1, 1'b1);
        idle(1, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_htrans", 32'(htrans), 32'd0);
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_mask", 32'(wr_mask), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        exp_q.delete();
        in_data     = 1'b0;
        mis_exp_cur = 1'b0;
        mis_issue   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(12, 1'b1);
        #2 chk("post_rst_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/marv32_store_queue.md
MARV32_STORE_QUEUE -- requirements
Module: marv32_store_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of store-queue entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width of the queue and the bus.
REQ-003 clk_in  input  1  clock; all state SHALL change on its rising edge.
REQ-004 reset_n_in  input  1  reset; asynchronous, active-low.
REQ-005 funct3_in  input  2  store size: 00 = SB, 01 = SH, 10 = SW, 11 = illegal.
REQ-006 iadder_in  input  AW  store byte address.
REQ-007 rs2_in  input  32  store source data.
REQ-008 mem_wr_req_in  input  1  store request, sampled every cycle.
REQ-009 ahb_ready_in  input  1  AHB HREADY.
REQ-010 d_addr_out  output  AW  AHB HADDR, word-aligned ({addr[AW-1:2],2'b00}).
REQ-011 data_out  output  32  AHB HWDATA, lane-steered.
REQ-012 wr_mask_out  output  4  byte strobes for the current transfer.
REQ-013 ahb_htrans_out  output  2  HTRANS: 00 = IDLE, 10 = NONSEQ.
REQ-014 wr_req_out  output  1  HWRITE; high during the address phase.
REQ-015 stall_out  output  1  queue full; a request in this cycle is rejected.
REQ-016 misaligned_out  output  1  one-cycle pulse for a rejected misaligned or illegal request.
REQ-017 empty_out  output  1  queue empty and bus idle; used for fence and drain.

Function
REQ-018 Lane steering SHALL be:
- SB: data = {4{rs2[7:0]}}, mask = 4'b0001 << addr[1:0].
- SH: data = {2{rs2[15:0]}}, mask = addr[1] ? 4'b1100 : 4'b0011.
- SW: data = rs2, mask = 4'b1111.
REQ-019 The following SHALL be misaligned: SH with addr[0]=1, SW with addr[1:0]!=0, or funct3=11. A misaligned request SHALL NOT be enqueued, and misaligned_out SHALL be high in the next cycle.
REQ-020 Enqueue SHALL occur when mem_wr_req_in=1, stall_out=0 and the request is aligned. The entry holds word address, steered data and mask.
REQ-021 stall_out SHALL equal (count==DEPTH), computed from registered count only. A same-cycle pop SHALL NOT admit a push when full.
REQ-022 Pointers SHALL be log2(DEPTH)+1 bits with a wrap bit. full = MSBs differ and lower bits equal; empty = pointers equal.
REQ-023 Bus FSM states SHALL be IDLE, ADDR, DATA.
- IDLE: htrans=00, wr_req_out=0. If the queue is not empty -> ADDR next cycle.
- ADDR: htrans=10, wr_req_out=1, d_addr_out/wr_mask_out from head. If ahb_ready_in=1 -> DATA; else hold ADDR with all outputs stable.
- DATA: htrans=00, data_out/wr_mask_out from head. If ahb_ready_in=1, pop head; then -> ADDR if count after pop >0, else IDLE. If ahb_ready_in=0, hold.
REQ-024 Minimum latency from enqueue to the first NONSEQ SHALL be 2 cycles (enqueue edge -> IDLE sees non-empty -> ADDR). Sustained throughput SHALL be one store per 2 cycles with zero wait states.
REQ-025 The head entry SHALL NOT change while in ADDR or DATA, whatever the push activity.
REQ-026 Outputs not owned by the current state (data_out in IDLE/ADDR, d_addr_out in IDLE/DATA) SHALL be driven to 0.
REQ-027 empty_out SHALL be 1 only when count==0 and the FSM is in IDLE.

Reset
REQ-028 Asserting reset_n_in low SHALL immediately clear pointers, count and misaligned_out, and force the FSM to IDLE. All outputs SHALL read 0 except stall_out=0 and empty_out=1.
REQ-029 Reset mid-transfer SHALL discard all queued stores with no further bus activity; in-flight data is lost.

Structure
REQ-030 The shared package marv32_pkg SHALL hold the funct3 store encodings, the HTRANS encodings (IDLE/NONSEQ), the FSM state enum, and the store-entry struct (addr, data, mask).
REQ-031 Lane steering and misalignment check SHALL live in one combinational sub-module, marv32_store_align. Queue storage and the FSM SHALL live in the top module.

Verification
REQ-032 Scenario: SB to 0x1003, rs2=0xA5, ready=1 -> ADDR phase with addr 0x1000, mask 1000, htrans 10; next cycle data 0xA5A5A5A5; empty_out=1 after.
REQ-033 Scenario: SH to 0x2002, rs2=0x1234BEEF -> mask 1100, data 0xBEEFBEEF; SW to 0x2001 -> misaligned_out pulse, no bus traffic.
REQ-034 Scenario: DEPTH=4, ready=0, five consecutive SW requests -> four accepted, stall_out=1 on the fifth; after ready=1, four transfers in push order.
REQ-035 Scenario: ready=0 for 3 cycles in ADDR then in DATA -> address, mask and data held stable; exactly one pop.
REQ-036 Scenario: pointer wrap: 10 stores through DEPTH=4 with ready=1 -> addresses and data emitted in order, no loss or duplication.
REQ-037 Scenario: reset_n_in low during DATA with 3 entries queued -> outputs zero immediately, empty_out=1, no further NONSEQ after release.
